// File: rtl/control_sequencer_if.sv
// Control-bus bundle between the microcode sequencer and the datapath it steers.
// The sequencer owns the master side; the datapath (or a bench) sits on the slave side.
interface control_sequencer_if;
    logic [3:0] opcode;
    logic       flag_carry;
    logic       flag_zero;

    logic       pc_out_en;
    logic       pc_enable;
    logic       pc_load;
    logic       mar_load;
    logic       ram_read;
    logic       ram_write;
    logic       ir_load;
    logic       ir_out;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_out;
    logic       alu_sub;
    logic       flags_load;
    logic       out_load;

    logic       halt;
    logic [2:0] step;

    modport master (
        input  opcode, flag_carry, flag_zero,
        output pc_out_en, pc_enable, pc_load, mar_load, ram_read, ram_write,
               ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, halt, step
    );

    modport slave (
        output opcode, flag_carry, flag_zero,
        input  pc_out_en, pc_enable, pc_load, mar_load, ram_read, ram_write,
               ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, halt, step
    );
endinterface

// File: rtl/control_sequencer.sv
// Five-microstep instruction sequencer: a T0..T4 step counter plus a halt latch,
// with every control line decoded combinationally from step, opcode and flags.
module control_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    control_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_e step_q, step_d;
    logic  halt_q, halt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= T0;
            halt_q <= 1'b0;
        end else begin
            step_q <= step_d;
            halt_q <= halt_d;
        end
    end

    // HLT latches on its T2 edge and the counter stays parked at T2 from then on.
    always_comb begin
        step_d = step_q;
        halt_d = halt_q;
        if (!halt_q) begin
            if (step_q == T2 && bus.opcode == OP_HLT) begin
                halt_d = 1'b1;
            end else begin
                case (step_q)
                    T0:      step_d = T1;
                    T1:      step_d = T2;
                    T2:      step_d = T3;
                    T3:      step_d = T4;
                    T4:      step_d = T0;
                    default: step_d = T0;
                endcase
            end
        end
    end

    always_comb begin
        bus.pc_out_en  = 1'b0;
        bus.pc_enable  = 1'b0;
        bus.pc_load    = 1'b0;
        bus.mar_load   = 1'b0;
        bus.ram_read   = 1'b0;
        bus.ram_write  = 1'b0;
        bus.ir_load    = 1'b0;
        bus.ir_out     = 1'b0;
        bus.a_load     = 1'b0;
        bus.a_out      = 1'b0;
        bus.b_load     = 1'b0;
        bus.alu_out    = 1'b0;
        bus.alu_sub    = 1'b0;
        bus.flags_load = 1'b0;
        bus.out_load   = 1'b0;

        // Reset and halt both force a quiet bus, independent of the registered state.
        if (!reset && !halt_q) begin
            case (step_q)
                T0: begin
                    bus.pc_out_en = 1'b1;
                    bus.mar_load  = 1'b1;
                end
                T1: begin
                    bus.ram_read  = 1'b1;
                    bus.ir_load   = 1'b1;
                    bus.pc_enable = 1'b1;
                end
                T2: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            bus.ir_out   = 1'b1;
                            bus.mar_load = 1'b1;
                        end
                        OP_LDI: begin
                            bus.ir_out = 1'b1;
                            bus.a_load = 1'b1;
                        end
                        OP_JMP: begin
                            bus.ir_out  = 1'b1;
                            bus.pc_load = 1'b1;
                        end
                        OP_JC: begin
                            bus.ir_out  = bus.flag_carry;
                            bus.pc_load = bus.flag_carry;
                        end
                        OP_JZ: begin
                            bus.ir_out  = bus.flag_zero;
                            bus.pc_load = bus.flag_zero;
                        end
                        OP_OUT: begin
                            bus.a_out    = 1'b1;
                            bus.out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            bus.ram_read = 1'b1;
                            bus.a_load   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            bus.ram_read = 1'b1;
                            bus.b_load   = 1'b1;
                        end
                        OP_STA: begin
                            bus.a_out     = 1'b1;
                            bus.ram_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        bus.alu_out    = 1'b1;
                        bus.a_load     = 1'b1;
                        bus.flags_load = 1'b1;
                        bus.alu_sub    = (bus.opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.halt = halt_q && !reset;
    assign bus.step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus a randomized run, each cycle
// compared against a microprogram-table model with its own step/halt bookkeeping.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [14:0] PCO  = 15'h4000;
    localparam logic [14:0] PCEN = 15'h2000;
    localparam logic [14:0] PCL  = 15'h1000;
    localparam logic [14:0] MARL = 15'h0800;
    localparam logic [14:0] RAMR = 15'h0400;
    localparam logic [14:0] RAMW = 15'h0200;
    localparam logic [14:0] IRL  = 15'h0100;
    localparam logic [14:0] IRO  = 15'h0080;
    localparam logic [14:0] AL   = 15'h0040;
    localparam logic [14:0] AO   = 15'h0020;
    localparam logic [14:0] BL   = 15'h0010;
    localparam logic [14:0] ALUO = 15'h0008;
    localparam logic [14:0] SUBM = 15'h0004;
    localparam logic [14:0] FL   = 15'h0002;
    localparam logic [14:0] OUTL = 15'h0001;

    logic [14:0] urom [16][5];
    int          m_step;
    bit          m_halt;
    int          passed = 0;
    int          total  = 0;

    wire [14:0] ctrl_v = {bus.pc_out_en, bus.pc_enable, bus.pc_load, bus.mar_load,
                          bus.ram_read, bus.ram_write, bus.ir_load, bus.ir_out,
                          bus.a_load, bus.a_out, bus.b_load, bus.alu_out,
                          bus.alu_sub, bus.flags_load, bus.out_load};
    wire [4:0]  drivers = {bus.pc_out_en, bus.ir_out, bus.ram_read, bus.a_out, bus.alu_out};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [14:0] exp_ctrl();
        logic [14:0] e;
        if (reset || m_halt) return 15'h0;
        e = urom[bus.opcode][m_step];
        if (m_step == 2 && ((bus.opcode == 4'h7 && !bus.flag_carry) ||
                            (bus.opcode == 4'h8 && !bus.flag_zero)))
            e = 15'h0;
        return e;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "/step"}, 32'(bus.step), 32'(m_step));
        chk({tag, "/halt"}, 32'(bus.halt), 32'(m_halt && !reset));
        chk({tag, "/ctrl"}, 32'(ctrl_v), 32'(exp_ctrl()));
        chk({tag, "/bus1"}, 32'($countones(drivers) <= 1), 32'd1);
        chk({tag, "/pcld_en"}, 32'(bus.pc_load & bus.pc_enable), 32'd0);
    endtask

    // Model advances from the inputs present just before the edge.
    task automatic tick();
        if (reset) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_step == 2 && bus.opcode == 4'hF) m_halt = 1'b1;
            else m_step = (m_step + 1) % 5;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 6 && m_step != target; k++) begin
            check_state("run_to");
            tick();
        end
        chk("run_to_reached", 32'(m_step), 32'(target));
    endtask

    initial begin
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 5; s++) urom[op][s] = 15'h0;
            urom[op][0] = PCO | MARL;
            urom[op][1] = RAMR | IRL | PCEN;
        end
        urom[1][2] = IRO | MARL;  urom[1][3] = RAMR | AL;
        urom[2][2] = IRO | MARL;  urom[2][3] = RAMR | BL;  urom[2][4] = ALUO | AL | FL;
        urom[3][2] = IRO | MARL;  urom[3][3] = RAMR | BL;  urom[3][4] = ALUO | AL | FL | SUBM;
        urom[4][2] = IRO | MARL;  urom[4][3] = AO | RAMW;
        urom[5][2] = IRO | AL;
        urom[6][2] = IRO | PCL;
        urom[7][2] = IRO | PCL;
        urom[8][2] = IRO | PCL;
        urom[14][2] = AO | OUTL;

        reset = 1'b1;
        bus.opcode = 4'h2;
        bus.flag_carry = 1'b0;
        bus.flag_zero = 1'b0;
        m_step = 0;
        m_halt = 1'b0;

        #1;
        chk("rst_ctrl_pre", 32'(ctrl_v), 32'd0);
        chk("rst_halt_pre", 32'(bus.halt), 32'd0);
        tick();
        check_state("rst1");
        tick();
        check_state("rst2");

        reset = 1'b0;
        #1;
        check_state("t0");
        chk("t0_pco", 32'(bus.pc_out_en), 32'd1);
        chk("t0_marl", 32'(bus.mar_load), 32'd1);
        tick();
        check_state("t1");
        chk("t1_irl", 32'(bus.ir_load), 32'd1);
        chk("t1_pcen", 32'(bus.pc_enable), 32'd1);
        tick();
        check_state("add_t2");
        tick();
        check_state("add_t3");
        tick();
        check_state("add_t4");
        chk("add_t4_aluo", 32'(bus.alu_out), 32'd1);
        chk("add_t4_sub", 32'(bus.alu_sub), 32'd0);
        tick();
        chk("add_wrap", 32'(bus.step), 32'd0);

        // JC not taken, then taken; carry toggles outside T2 must not matter.
        bus.opcode = 4'h7;
        bus.flag_carry = 1'b1;
        run_to(2);
        bus.flag_carry = 1'b0;
        #1;
        check_state("jc_c0");
        chk("jc_c0_pcl", 32'(bus.pc_load), 32'd0);
        run_to(0);
        bus.flag_carry = 1'b0;
        run_to(2);
        bus.flag_carry = 1'b1;
        #1;
        check_state("jc_c1");
        chk("jc_c1_pcl", 32'(bus.pc_load), 32'd1);
        chk("jc_c1_iro", 32'(bus.ir_out), 32'd1);
        run_to(0);

        // Reset in the middle of STA's write cycle.
        bus.opcode = 4'h4;
        run_to(3);
        chk("sta_t3_ramw", 32'(bus.ram_write), 32'd1);
        reset = 1'b1;
        #1;
        check_state("sta_rst");
        chk("sta_rst_ramw", 32'(bus.ram_write), 32'd0);
        tick();
        chk("sta_rst_step", 32'(bus.step), 32'd0);
        reset = 1'b0;
        #1;

        // Sweep opcodes 0..E with every flag combination across a full instruction.
        for (int op = 0; op < 15; op++) begin
            for (int fl = 0; fl < 4; fl++) begin
                bus.opcode = 4'(op);
                bus.flag_carry = fl[0];
                bus.flag_zero = fl[1];
                #1;
                for (int s = 0; s < 5; s++) begin
                    check_state("sweep");
                    tick();
                end
            end
        end

        // Randomized traffic with occasional resets landing mid-instruction.
        for (int i = 0; i < 1000; i++) begin
            if (m_step == 1) bus.opcode = 4'($urandom_range(0, 14));
            bus.flag_carry = 1'($urandom);
            bus.flag_zero = 1'($urandom);
            reset = ($urandom_range(0, 39) == 0);
            #1;
            check_state("rand");
            tick();
        end
        reset = 1'b0;
        #1;

        // HLT: freeze at step 2 with a quiet bus until reset.
        bus.opcode = 4'hF;
        run_to(2);
        check_state("hlt_t2");
        tick();
        chk("hlt_halt", 32'(bus.halt), 32'd1);
        chk("hlt_step", 32'(bus.step), 32'd2);
        for (int i = 0; i < 10; i++) begin
            bus.flag_carry = 1'($urandom);
            bus.flag_zero = 1'($urandom);
            #1;
            check_state("hlt_hold");
            tick();
        end
        reset = 1'b1;
        #1;
        check_state("hlt_rst");
        chk("hlt_rst_halt", 32'(bus.halt), 32'd0);
        tick();
        chk("hlt_rst_step", 32'(bus.step), 32'd0);
        reset = 1'b0;
        bus.opcode = 4'h0;
        #1;
        check_state("post_hlt_t0");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL provide port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL provide port opcode, input, 4 bits: upper nibble of the instruction register, stable from the end of T1 until the next T1.
REQ-004 The block SHALL provide port flag_carry, input, 1 bit, and port flag_zero, input, 1 bit: latched ALU flags.
REQ-005 The block SHALL provide these 1-bit control outputs: pc_out_en, pc_enable, pc_load, mar_load, ram_read, ram_write, ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load.
REQ-006 The block SHALL provide port halt, output, 1 bit: the processor is stopped.
REQ-007 The block SHALL provide port step, output, 3 bits: the current microstep T0..T4, for debug.

Function
REQ-008 The block SHALL hold a 3-bit step counter that advances 0->1->2->3->4->0 on every rising clock edge while not halted and not in reset.
REQ-009 Control outputs SHALL be combinational decodes of step, opcode and flags; outputs not listed for a step SHALL be 0.
REQ-010 T0 (fetch) SHALL assert pc_out_en and mar_load.
REQ-011 T1 (fetch) SHALL assert ram_read, ir_load and pc_enable.
REQ-012 LDA (0x1) SHALL assert ir_out and mar_load at T2, and ram_read and a_load at T3.
REQ-013 ADD (0x2) SHALL assert ir_out and mar_load at T2, ram_read and b_load at T3, and alu_out, a_load and flags_load at T4.
REQ-014 SUB (0x3) SHALL behave as ADD, and SHALL additionally assert alu_sub at T4.
REQ-015 STA (0x4) SHALL assert ir_out and mar_load at T2, and a_out and ram_write at T3.
REQ-016 LDI (0x5) SHALL assert ir_out and a_load at T2.
REQ-017 JMP (0x6) SHALL assert ir_out and pc_load at T2.
REQ-018 JC (0x7) SHALL assert ir_out and pc_load at T2 only if flag_carry=1; otherwise T2 SHALL be idle.
REQ-019 JZ (0x8) SHALL assert ir_out and pc_load at T2 only if flag_zero=1; otherwise T2 SHALL be idle.
REQ-020 OUT (0xE) SHALL assert a_out and out_load at T2.
REQ-021 HLT (0xF) SHALL set the halt register at the T2 edge; halt SHALL then remain 1, step SHALL freeze at 2, and all control outputs SHALL be 0 until reset.
REQ-022 NOP (0x0) and undefined opcodes (0x9-0xD) SHALL be idle for T2-T4, so that every instruction takes exactly 5 cycles.
REQ-023 At most one bus driver (pc_out_en, ir_out, ram_read, a_out, alu_out) SHALL be asserted in any cycle.
REQ-024 pc_load and pc_enable SHALL never be asserted in the same cycle.
REQ-025 JC and JZ SHALL sample flags combinationally during T2; a flag change at any other step SHALL have no effect on the branch.

Reset
REQ-026 While reset=1, all control outputs and halt SHALL be 0.
REQ-027 On the first rising edge with reset=1, step SHALL become 0 and halt SHALL clear.
REQ-028 Reset SHALL take priority over counting and halt in any step, including mid-instruction.
REQ-029 After reset deasserts, the next cycle SHALL be T0, with pc_out_en=1 and mar_load=1.

Verification
REQ-030 Hold reset 2 cycles, then release -> step=0, pc_out_en=1, mar_load=1; next cycle step=1, ir_load=1, pc_enable=1.
REQ-031 Set opcode=0x2 and run 5 cycles -> step sequence 0,1,2,3,4, T4 asserts alu_out, a_load and flags_load with alu_sub=0, then step wraps to 0.
REQ-032 Run opcode=0x7: with flag_carry=0 -> pc_load=0 at T2; with flag_carry=1 -> pc_load=1 and ir_out=1 at T2.
REQ-033 Run opcode=0xF -> halt=1 after the T2 edge, step stays 2 for 10 cycles with all controls 0; then reset=1 -> halt=0 and step=0.
REQ-034 Assert reset at T3 of STA (0x4) -> ram_write=0 in the reset cycle and step=0 after the edge.
REQ-035 Sweep all 16 opcodes through all steps and flag combinations -> at most one bus driver per cycle, and pc_load and pc_enable never asserted together.
